// File: rtl/bitmat_engine.sv
// rtl/bitmat_engine.sv - boolean outer-product accumulator with row-by-row readout
// Accumulates C op= a*b^T per input beat, then streams the N result rows.
module bitmat_engine #(
  parameter int N  = 8,
  parameter int KW = 8,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [KW-1:0] k_len,
  input  logic          abort,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [RW-1:0] out_row,
  output logic          out_last
);

  typedef enum logic [1:0] {IDLE, ACCUM, READOUT} state_t;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  state_t        state;
  logic [N-1:0]  c [N];
  logic [KW-1:0] cnt;
  logic [1:0]    op;
  logic [RW-1:0] row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= OP_OR;
      row   <= '0;
      for (int i = 0; i < N; i++) c[i] <= '0;
    end else if (abort) begin
      state <= IDLE;
      cnt   <= '0;
      row   <= '0;
      for (int i = 0; i < N; i++) c[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // mode 11 is folded into OR so the datapath only sees three ops
            op    <= (mode == 2'b11) ? OP_OR : mode;
            cnt   <= k_len;
            row   <= '0;
            for (int i = 0; i < N; i++) c[i] <= (mode == OP_AND) ? '1 : '0;
            state <= (k_len != '0) ? ACCUM : READOUT;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) begin
              unique case (op)
                OP_XOR:  c[i] <= c[i] ^ (in_b & {N{in_a[i]}});
                OP_AND:  c[i] <= c[i] & (in_b & {N{in_a[i]}});
                default: c[i] <= c[i] | (in_b & {N{in_a[i]}});
              endcase
            end
            cnt <= cnt - 1'b1;
            if (cnt == KW'(1)) state <= READOUT;
          end
        end
        READOUT: begin
          if (out_ready) begin
            if (row == RW'(N - 1)) begin
              state <= IDLE;
              row   <= '0;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == READOUT);
  assign out_row   = row;
  assign out_data  = out_valid ? c[row] : '0;
  assign out_last  = out_valid && (row == RW'(N - 1));

endmodule

// File: doc/bitmat_engine.md
BITMAT_ENGINE -- requirements
Module: bitmat_engine

Interface
REQ-001 Parameter N, default 8, SHALL set matrix dimension and vector width; legal range 2..16.
REQ-002 Parameter KW, default 8, SHALL set width of the vector-count field k_len.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 start  input  1  single-cycle request to begin a job; honoured only in IDLE.
REQ-006 mode  input  2  accumulate op, sampled on accepted start: 00 OR, 01 XOR, 10 AND, 11 treated as OR.
REQ-007 k_len  input  KW  number of vector pairs in the job, sampled on accepted start.
REQ-008 abort  input  1  synchronous job cancel.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 in_valid / in_ready  input / output  1 / 1  handshake for input beats; a beat transfers when both are high on a rising edge.
REQ-011 in_a, in_b  input  N each  column vector a and row vector b of one beat.
REQ-012 out_valid / out_ready  output / input  1 / 1  handshake for result rows.
REQ-013 out_data  output  N  result row; bit j of row i = C[i][j].
REQ-014 out_row  output  $clog2(N)  index of the row currently presented.
REQ-015 out_last  output  1  high with row N-1.

Function
REQ-016 States SHALL be IDLE, ACCUM and READOUT.
REQ-017 IDLE -> ACCUM on start when k_len != 0; IDLE -> READOUT on start when k_len == 0; start outside IDLE SHALL be ignored.
REQ-018 On accepted start, every C[i][j] SHALL load its identity: 0 for OR/XOR, 1 for AND; the beat counter SHALL load k_len.
REQ-019 In ACCUM, in_ready SHALL be 1; elsewhere in_ready SHALL be 0.
REQ-020 Each transferred beat SHALL update every cell on the same edge: C[i][j] <= C[i][j] op (in_a[i] & in_b[j]), where op is the sampled mode.
REQ-021 Each transferred beat SHALL decrement the beat counter; the edge that transfers the final beat SHALL move the state to READOUT with that beat included.
REQ-022 Cycles in ACCUM with in_valid low SHALL leave C and the counter unchanged.
REQ-023 In READOUT, out_valid SHALL be 1 and out_data SHALL show the row at out_row, starting at row 0 on the first READOUT cycle.
REQ-024 out_data, out_row and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 A transferred row SHALL advance out_row by 1; transfer of row N-1 SHALL return the state to IDLE with no gap cycle.
REQ-026 Outside READOUT: out_valid, out_last and out_data SHALL be 0, and out_row SHALL be 0.
REQ-027 C SHALL hold its value after READOUT until the next accepted start.
REQ-028 abort=1 in any state SHALL force IDLE on the next edge and clear C and the counter to 0; abort SHALL take priority over start, beats and row transfers on the same edge.
REQ-029 Result SHALL be independent of beat spacing; throughput SHALL be one beat per cycle and one row per cycle.

Reset
REQ-030 While rst_n=0: state IDLE, C all 0, counter 0, busy=0, in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0.
REQ-031 Reset asserted mid-job SHALL abandon the job with no partial output; the first edge after release SHALL see IDLE.

Verification
REQ-032 N=8, mode=00, k_len=1, a=8'h81, b=8'hFF, out_ready=1 -> 8 rows, rows 0 and 7 = FF, others 00, out_last with row 7, busy drops the cycle after row 7.
REQ-033 mode=01, k_len=2, both beats a=8'h01, b=8'h0F -> row 0 = 00 (XOR cancels), all rows 00; repeat with mode=00 -> row 0 = 0F.
REQ-034 mode=10, k_len=2, beats (FF,FF) then (FF,F0) -> every row F0; k_len=0 with mode=10 -> 8 rows of FF; with mode=00 -> 8 rows of 00.
REQ-035 Random in_valid gaps and out_ready stalls over 1000 random jobs (all modes, k_len 0..20) -> output matches a software model; out_data stable during stalls.
REQ-036 abort during ACCUM at beat 3 of 5 -> IDLE next cycle, no out_valid; following job gives correct result.
REQ-037 rst_n pulsed low during READOUT row 4 -> all outputs 0 immediately (asynchronous); start ignored while busy; a fresh job after release gives correct result.
